ps2_ascii_src: RTL and testbench

Keyboard front end that feeds the MD5 string-builder stage. It receives PS/2 scan-code set 2 frames and tracks make, break, extended and shift state. Printable keys become ASCII, which the block queues and presents on `ascii`/`en`. The output timing is sized so the downstream stage, which samples on its divided `kbdclk` (period 202 `clk` cycles), sees each character exactly once on `en` and still finds it on `ascii` at its following sample edge.

---
 rtl/ps2_ascii_src.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ps2_ascii_src.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_src.sv
// ps2_ascii_src: PS/2 (scan-code set 2) keyboard front end for the MD5 string builder.
// Receives 11-bit PS/2 frames, tracks make/break/extended/shift state, converts
// printable make codes to ASCII, queues them and presents each character for one
// downstream kbdclk period with en=1 followed by one period with en=0.
// Ports:
//   clk       in  system clock
//   reset     in  asynchronous active-low reset
//   ps2_clk   in  PS/2 clock line (asynchronous)
//   ps2_data  in  PS/2 data line (asynchronous)
//   ascii     out character presented downstream, 8'h00 when idle
//   en        out character-valid strobe, high for HOLD_CYCLES per character
//   frame_err out one-cycle pulse on start/parity/stop error or timeout
//   overflow  out sticky flag, a character was dropped on a full queue
module ps2_ascii_src #(
  parameter int HOLD_CYCLES = 202,
  parameter int TIMEOUT     = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii,
  output logic       en,
  output logic       frame_err,
  output logic       overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1, ST_KEEP = 2'd2} state_t;

  // Maps a make code to {valid, ascii}; letters are shifted to uppercase when upper=1.
  function automatic logic [8:0] map_make(input logic [7:0] code, input logic upper);
    logic [7:0] c;
    logic       letter;
    logic       valid;
    c      = 8'h00;
    letter = 1'b1;
    valid  = 1'b1;
    case (code)
      8'h1C: c = 8'h61;  8'h32: c = 8'h62;  8'h21: c = 8'h63;  8'h23: c = 8'h64;
      8'h24: c = 8'h65;  8'h2B: c = 8'h66;  8'h34: c = 8'h67;  8'h33: c = 8'h68;
      8'h43: c = 8'h69;  8'h3B: c = 8'h6A;  8'h42: c = 8'h6B;  8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D;  8'h31: c = 8'h6E;  8'h44: c = 8'h6F;  8'h4D: c = 8'h70;
      8'h15: c = 8'h71;  8'h2D: c = 8'h72;  8'h1B: c = 8'h73;  8'h2C: c = 8'h74;
      8'h3C: c = 8'h75;  8'h2A: c = 8'h76;  8'h1D: c = 8'h77;  8'h22: c = 8'h78;
      8'h35: c = 8'h79;  8'h1A: c = 8'h7A;
      8'h45: begin c = 8'h30; letter = 1'b0; end
      8'h16: begin c = 8'h31; letter = 1'b0; end
      8'h1E: begin c = 8'h32; letter = 1'b0; end
      8'h26: begin c = 8'h33; letter = 1'b0; end
      8'h25: begin c = 8'h34; letter = 1'b0; end
      8'h2E: begin c = 8'h35; letter = 1'b0; end
      8'h36: begin c = 8'h36; letter = 1'b0; end
      8'h3D: begin c = 8'h37; letter = 1'b0; end
      8'h3E: begin c = 8'h38; letter = 1'b0; end
      8'h46: begin c = 8'h39; letter = 1'b0; end
      8'h29: begin c = 8'h20; letter = 1'b0; end
      8'h5A: begin c = 8'h0D; letter = 1'b0; end
      8'h66: begin c = 8'h08; letter = 1'b0; end
      default: begin letter = 1'b0; valid = 1'b0; end
    endcase
    if (letter && upper) begin
      c = c - 8'h20;
    end else begin
      c = c;
    end
    return {valid, c};
  endfunction

  // Synchroniser and edge-detect state
  logic ps2_clk_meta_r, ps2_clk_sync_r, ps2_clk_prev_r;
  logic ps2_data_meta_r, ps2_data_sync_r;
  logic fall_s;

  // Receiver state
  logic [3:0]      bit_cnt_r;
  logic [8:0]      rx_sr_r;
  logic [TO_W-1:0] to_cnt_r;
  logic [7:0]      rx_byte_r;
  logic            rx_valid_r;

  // Decoder state
  logic       brk_r, ext_r, shift_l_r, shift_r_r;
  logic [7:0] char_r;
  logic       char_valid_r;
  logic [8:0] map_s;

  // Queue and output FSM
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic             empty_s, full_s, pop_s, push_ok_s;
  state_t           state_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  assign fall_s = ps2_clk_prev_r & ~ps2_clk_sync_r;
  assign map_s  = map_make(rx_byte_r, shift_l_r | shift_r_r);

  // One slot stays unused so full and empty are distinguishable by pointer compare.
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (PTR_W'(wr_ptr_r + PTR_W'(1)) == rd_ptr_r);
  assign pop_s     = ~empty_s & ((state_r == ST_IDLE) |
                                 ((state_r == ST_KEEP) & (hold_cnt_r == HOLD_LAST)));
  assign push_ok_s = ~full_s | pop_s;

  // Two-flop synchronisers for both PS/2 lines plus the previous clock sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2_clk_meta_r  <= 1'b1;
      ps2_clk_sync_r  <= 1'b1;
      ps2_clk_prev_r  <= 1'b1;
      ps2_data_meta_r <= 1'b1;
      ps2_data_sync_r <= 1'b1;
    end else begin
      ps2_clk_meta_r  <= ps2_clk;
      ps2_clk_sync_r  <= ps2_clk_meta_r;
      ps2_clk_prev_r  <= ps2_clk_sync_r;
      ps2_data_meta_r <= ps2_data;
      ps2_data_sync_r <= ps2_data_meta_r;
    end
  end

  // Frame receiver: shifts bits on each falling edge, checks framing, watches for timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_r  <= 4'd0;
      rx_sr_r    <= 9'd0;
      to_cnt_r   <= '0;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_s) begin
        to_cnt_r <= '0;
        case (bit_cnt_r)
          4'd0: begin
            if (!ps2_data_sync_r) begin
              bit_cnt_r <= 4'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          4'd10: begin
            // Parity and stop are judged together so a bad frame yields one error.
            bit_cnt_r <= 4'd0;
            if (ps2_data_sync_r && (^rx_sr_r)) begin
              rx_byte_r  <= rx_sr_r[7:0];
              rx_valid_r <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            rx_sr_r   <= {ps2_data_sync_r, rx_sr_r[8:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        endcase
      end else if (bit_cnt_r != 4'd0) begin
        if (to_cnt_r == TO_LAST) begin
          to_cnt_r  <= '0;
          bit_cnt_r <= 4'd0;
          frame_err <= 1'b1;
        end else begin
          to_cnt_r <= to_cnt_r + TO_W'(1);
        end
      end else begin
        to_cnt_r <= '0;
      end
    end
  end

  // Scan-code decoder: prefix flags, shift tracking and ASCII generation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk_r        <= 1'b0;
      ext_r        <= 1'b0;
      shift_l_r    <= 1'b0;
      shift_r_r    <= 1'b0;
      char_r       <= 8'h00;
      char_valid_r <= 1'b0;
    end else begin
      char_valid_r <= 1'b0;
      if (rx_valid_r) begin
        if (rx_byte_r == 8'hF0) begin
          brk_r <= 1'b1;
        end else if (rx_byte_r == 8'hE0) begin
          ext_r <= 1'b1;
        end else begin
          brk_r <= 1'b0;
          ext_r <= 1'b0;
          if (rx_byte_r == 8'h12) begin
            shift_l_r <= ~brk_r;
          end else if (rx_byte_r == 8'h59) begin
            shift_r_r <= ~brk_r;
          end else begin
            shift_l_r <= shift_l_r;
          end
          if (!brk_r && ext_r) begin
            char_r       <= 8'h0D;
            char_valid_r <= (rx_byte_r == 8'h5A);
          end else if (!brk_r) begin
            char_r       <= map_s[7:0];
            char_valid_r <= map_s[8];
          end else begin
            char_valid_r <= 1'b0;
          end
        end
      end
    end
  end

  // Character queue: write on decoded make, drop and flag overflow when full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (char_valid_r && push_ok_s) begin
        mem_r[wr_ptr_r] <= char_r;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else if (char_valid_r) begin
        overflow <= 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Output FSM: IDLE -> SHOW (en=1) -> KEEP (en=0) -> SHOW or IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= '0;
      ascii      <= 8'h00;
      en         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          hold_cnt_r <= '0;
          if (pop_s) begin
            ascii   <= mem_r[rd_ptr_r];
            en      <= 1'b1;
            state_r <= ST_SHOW;
          end else begin
            ascii <= 8'h00;
            en    <= 1'b0;
          end
        end
        ST_SHOW: begin
          if (hold_cnt_r == HOLD_LAST) begin
            hold_cnt_r <= '0;
            en         <= 1'b0;
            state_r    <= ST_KEEP;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_KEEP: begin
          if (hold_cnt_r == HOLD_LAST) begin
            hold_cnt_r <= '0;
            if (pop_s) begin
              ascii   <= mem_r[rd_ptr_r];
              en      <= 1'b1;
              state_r <= ST_SHOW;
            end else begin
              ascii   <= 8'h00;
              en      <= 1'b0;
              state_r <= ST_IDLE;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          hold_cnt_r <= '0;
          ascii      <= 8'h00;
          en         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_ascii_src.sv
// Self-checking bench for ps2_ascii_src: table of single keystrokes plus
// hand-written sequences; expected characters go to a scoreboard queue and are
// compared when en rises.
module tb_ps2_ascii_src;

  localparam int HOLD  = 202;
  localparam int CLK_P = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ascii;
  logic       en;
  logic       frame_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb_q[$];
  time stop_fall_t = 0;
  time last_rise_t = 0;
  int  rise_cnt = 0;
  int  fe_cnt = 0;
  int  last_latency = 0;

  always #5 clk = ~clk;

  ps2_ascii_src dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ascii(ascii), .en(en), .frame_err(frame_err), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops on en rise, plus strobe width and spacing checks.
  logic       prev_en = 1'b0;
  logic       prev_fe = 1'b0;
  logic [7:0] prev_ascii = 8'h00;
  int         high_cnt = 0;
  always @(negedge clk) begin
    if (en && !prev_en) begin
      rise_cnt++;
      last_latency = int'(($time - stop_fall_t) / CLK_P);
      if (sb_q.size() == 0) check("spurious_char", sb_q.size(), 1);
      else check("char", ascii, sb_q.pop_front());
      if (prev_ascii != 8'h00) check("b2b_spacing", int'(($time - last_rise_t) / CLK_P), 404);
      last_rise_t = $time;
      high_cnt = 1;
    end else if (en) begin
      high_cnt++;
    end
    if (!en && prev_en && reset) check("en_width", high_cnt, HOLD);
    if (frame_err) begin
      fe_cnt++;
      check("fe_width", prev_fe, 0);
    end
    prev_en    = en;
    prev_fe    = frame_err;
    prev_ascii = ascii;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #(95000 * CLK_P);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic send_bits(input logic [10:0] fr, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_fall_t = $time;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int half, input logic bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_bits(fr, 11, half);
  endtask

  task automatic wait_idle(input int max_cycles);
    logic ok;
    ok = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && ascii == 8'h00 && !en) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", ok, 1);
  endtask

  task automatic wait_rise(input int r0, input string nm);
    for (int i = 0; i < 2000; i++) begin
      if (rise_cnt > r0) break;
      @(negedge clk);
    end
    check(nm, rise_cnt - r0, 1);
  endtask

  task automatic at_offset(input int n);
    while ($time < last_rise_t + n * CLK_P) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] code;
    logic       shift;
    logic       has_out;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];
  int   r0;
  int   f0;

  initial begin
    tbl[0]  = '{8'h1C, 1'b0, 1'b1, 8'h61};
    tbl[1]  = '{8'h1A, 1'b1, 1'b1, 8'h5A};
    tbl[2]  = '{8'h45, 1'b0, 1'b1, 8'h30};
    tbl[3]  = '{8'h46, 1'b1, 1'b1, 8'h39};
    tbl[4]  = '{8'h29, 1'b0, 1'b1, 8'h20};
    tbl[5]  = '{8'h5A, 1'b0, 1'b1, 8'h0D};
    tbl[6]  = '{8'h66, 1'b0, 1'b1, 8'h08};
    tbl[7]  = '{8'h4D, 1'b1, 1'b1, 8'h50};
    tbl[8]  = '{8'h2A, 1'b0, 1'b1, 8'h76};
    tbl[9]  = '{8'h0E, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{8'h16, 1'b1, 1'b1, 8'h31};
    tbl[11] = '{8'h3B, 1'b0, 1'b1, 8'h6A};

    // Reset values
    repeat (5) @(negedge clk);
    check("rst_ascii", ascii, 8'h00);
    check("rst_en", en, 0);
    check("rst_fe", frame_err, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Single 'a' at slow PS/2 clock: latency and SHOW/KEEP timing
    r0 = rise_cnt;
    sb_q.push_back(8'h61);
    send_byte(8'h1C, 40, 1'b0);
    wait_rise(r0, "t1_rise");
    check("t1_latency", last_latency, 6);
    at_offset(201); check("t1_show_end_en", en, 1); check("t1_show_end_ascii", ascii, 8'h61);
    at_offset(202); check("t1_keep_en", en, 0);     check("t1_keep_ascii", ascii, 8'h61);
    at_offset(403); check("t1_keep_end_ascii", ascii, 8'h61);
    at_offset(404); check("t1_idle_ascii", ascii, 8'h00);

    // Table of single keystrokes, optionally wrapped in left shift
    foreach (tbl[k]) begin
      r0 = rise_cnt;
      if (tbl[k].shift) send_byte(8'h12, 8, 1'b0);
      if (tbl[k].has_out) sb_q.push_back(tbl[k].exp);
      send_byte(tbl[k].code, 8, 1'b0);
      if (tbl[k].shift) begin
        send_byte(8'hF0, 8, 1'b0);
        send_byte(8'h12, 8, 1'b0);
      end
      wait_idle(1500);
      check("tbl_count", rise_cnt - r0, {31'd0, tbl[k].has_out});
    end

    // Shift, make, breaks, release shift, make again
    r0 = rise_cnt;
    send_byte(8'h12, 8, 1'b0);
    sb_q.push_back(8'h41);
    send_byte(8'h1C, 8, 1'b0);
    send_byte(8'hF0, 8, 1'b0); send_byte(8'h1C, 8, 1'b0);
    send_byte(8'hF0, 8, 1'b0); send_byte(8'h12, 8, 1'b0);
    sb_q.push_back(8'h61);
    send_byte(8'h1C, 8, 1'b0);
    wait_idle(3000);
    check("seq_count", rise_cnt - r0, 2);

    // Bad parity, then extended codes
    r0 = rise_cnt;
    f0 = fe_cnt;
    send_byte(8'h5A, 8, 1'b1);
    repeat (20) @(negedge clk);
    check("parity_err", fe_cnt - f0, 1);
    send_byte(8'hE0, 8, 1'b0); send_byte(8'h1C, 8, 1'b0);
    sb_q.push_back(8'h0D);
    send_byte(8'hE0, 8, 1'b0); send_byte(8'h5A, 8, 1'b0);
    wait_idle(2000);
    check("ext_count", rise_cnt - r0, 1);

    // Burst faster than drain: three fit behind the displayed one, the fifth is dropped
    r0 = rise_cnt;
    check("ovf_before", overflow, 0);
    sb_q.push_back(8'h71); sb_q.push_back(8'h77);
    sb_q.push_back(8'h65); sb_q.push_back(8'h72);
    send_byte(8'h15, 3, 1'b0); send_byte(8'h1D, 3, 1'b0); send_byte(8'h24, 3, 1'b0);
    send_byte(8'h2D, 3, 1'b0); send_byte(8'h2C, 3, 1'b0);
    repeat (10) @(negedge clk);
    check("ovf_set", overflow, 1);
    wait_idle(3000);
    check("burst_count", rise_cnt - r0, 4);
    check("ovf_sticky", overflow, 1);

    // Truncated frame (start + 6 data bits) then silence
    f0 = fe_cnt;
    send_bits(11'b000_0011_0110, 7, 8);
    repeat (49900) @(negedge clk);
    check("timeout_early", fe_cnt - f0, 0);
    for (int i = 0; i < 300; i++) begin
      if (fe_cnt != f0) break;
      @(negedge clk);
    end
    check("timeout_err", fe_cnt - f0, 1);
    r0 = rise_cnt;
    sb_q.push_back(8'h20);
    send_byte(8'h29, 8, 1'b0);
    wait_idle(2000);
    check("after_timeout", rise_cnt - r0, 1);

    // Reset during SHOW
    r0 = rise_cnt;
    sb_q.push_back(8'h61);
    send_byte(8'h1C, 8, 1'b0);
    wait_rise(r0, "rst_show_rise");
    repeat (30) @(negedge clk);
    check("pre_rst_en", en, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_en", en, 0);
    check("mid_rst_ascii", ascii, 8'h00);
    check("mid_rst_ovf", overflow, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    r0 = rise_cnt;
    sb_q.push_back(8'h31);
    send_byte(8'h16, 8, 1'b0);
    wait_rise(r0, "post_rst_rise");
    check("post_rst_latency", last_latency, 6);
    wait_idle(1500);

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
